// File: rtl/r305_cmd_tx.sv
// ============================================================================
// Module   : r305_cmd_tx
// Brief    : R305 fingerprint command packet framer feeding a byte UART TX.
//            Optional pkt_count output when R305_PKT_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module r305_cmd_tx #(
    parameter logic [31:0] ADDR = 32'hFFFF_FFFF
) (
    input  logic        fp_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_code,
    input  logic [2:0]  param_len,
    input  logic [39:0] params,
    output logic        cmd_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        pkt_done
`ifdef R305_PKT_COUNT_EN
    ,
    output logic [7:0]  pkt_count
`endif
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_SEND = 3'd1;
    localparam logic [2:0] c_HOLD = 3'd2;
    localparam logic [2:0] c_WAIT = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;

    logic [2:0]  state_q,  state_d;
    logic [4:0]  idx_q,    idx_d;
    logic [7:0]  cmd_q,    cmd_d;
    logic [39:0] params_q, params_d;
    logic [2:0]  n_q,      n_d;
    logic [15:0] chk_q,    chk_d;
    logic [7:0]  last_q,   last_d;

    logic [4:0]  w_chk_idx;
    logic [4:0]  w_last_idx;
    logic [7:0]  w_cur_byte;
    logic        w_in_sum;
    logic        w_is_param;

    assign w_chk_idx  = 5'd10 + {2'b00, n_q};
    assign w_last_idx = w_chk_idx + 5'd1;
    assign w_is_param = (idx_q >= 5'd10) && (idx_q < w_chk_idx);
    assign w_in_sum   = (idx_q >= 5'd6) && (idx_q < w_chk_idx);

    // Param bytes always come from the top of params_q, which shifts as each one goes out.
    always_comb begin
        case (idx_q)
            5'd0:    w_cur_byte = 8'hEF;
            5'd1:    w_cur_byte = 8'h01;
            5'd2:    w_cur_byte = ADDR[31:24];
            5'd3:    w_cur_byte = ADDR[23:16];
            5'd4:    w_cur_byte = ADDR[15:8];
            5'd5:    w_cur_byte = ADDR[7:0];
            5'd6:    w_cur_byte = 8'h01;
            5'd7:    w_cur_byte = 8'h00;
            5'd8:    w_cur_byte = {5'd0, n_q} + 8'd3;
            5'd9:    w_cur_byte = cmd_q;
            default: begin
                if (w_is_param)
                    w_cur_byte = params_q[39:32];
                else if (idx_q == w_chk_idx)
                    w_cur_byte = chk_q[15:8];
                else
                    w_cur_byte = chk_q[7:0];
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cmd_d    = cmd_q;
        params_d = params_q;
        n_d      = n_q;
        chk_d    = chk_q;
        last_d   = last_q;
        case (state_q)
            c_IDLE: begin
                idx_d = 5'd0;
                if (cmd_valid) begin
                    cmd_d    = cmd_code;
                    params_d = params;
                    n_d      = (param_len > 3'd5) ? 3'd5 : param_len;
                    chk_d    = 16'd0;
                    state_d  = c_SEND;
                end
            end
            c_SEND: begin
                if (!tx_busy) begin
                    last_d = w_cur_byte;
                    if (w_in_sum)
                        chk_d = chk_q + {8'd0, w_cur_byte};
                    if (w_is_param)
                        params_d = {params_q[31:0], 8'd0};
                    state_d = c_HOLD;
                end
            end
            // Covers the transmitter's one-cycle busy latency.
            c_HOLD: state_d = c_WAIT;
            c_WAIT: begin
                if (!tx_busy) begin
                    if (idx_q == w_last_idx) begin
                        state_d = c_DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = c_SEND;
                    end
                end
            end
            c_DONE: begin
                idx_d   = 5'd0;
                state_d = c_IDLE;
            end
            default: begin
                idx_d   = 5'd0;
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge fp_clk) begin
        if (reset) begin
            state_q  <= c_IDLE;
            idx_q    <= 5'd0;
            cmd_q    <= 8'd0;
            params_q <= 40'd0;
            n_q      <= 3'd0;
            chk_q    <= 16'd0;
            last_q   <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cmd_q    <= cmd_d;
            params_q <= params_d;
            n_q      <= n_d;
            chk_q    <= chk_d;
            last_q   <= last_d;
        end
    end

    assign cmd_ready = (state_q == c_IDLE);
    assign tx_start  = (state_q == c_SEND) && !tx_busy;
    assign tx_data   = tx_start ? w_cur_byte : last_q;
    assign pkt_done  = (state_q == c_DONE);

`ifdef R305_PKT_COUNT_EN
    logic [7:0] pkt_count_q, pkt_count_d;

    assign pkt_count_d = pkt_done ? pkt_count_q + 8'd1 : pkt_count_q;

    always_ff @(posedge fp_clk) begin
        if (reset)
            pkt_count_q <= 8'd0;
        else
            pkt_count_q <= pkt_count_d;
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_r305_cmd_tx.sv
// ============================================================================
// Module   : tb_r305_cmd_tx
// Brief    : Self-checking bench for r305_cmd_tx with a byte UART busy model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_r305_cmd_tx;

    logic        fp_clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_code = 8'd0;
    logic [2:0]  param_len = 3'd0;
    logic [39:0] params = 40'd0;
    logic        cmd_ready, tx_start, pkt_done, tx_busy;
    logic [7:0]  tx_data;
`ifdef R305_PKT_COUNT_EN
    logic [7:0]  pkt_count;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         done_cnt = 0;
    int         consec_err = 0;
    bit         prev_start = 1'b0;
    int         busy_len = 10;
    int         busy_cnt = 0;
    bit         busy_force = 1'b0;

    r305_cmd_tx dut (
        .fp_clk    (fp_clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .param_len (param_len),
        .params    (params),
        .cmd_ready (cmd_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .pkt_done  (pkt_done)
`ifdef R305_PKT_COUNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    always #5 fp_clk = ~fp_clk;

    // Byte UART model: busy from the cycle after tx_start for busy_len cycles.
    always @(posedge fp_clk) begin
        if (tx_start)
            busy_cnt <= busy_len;
        else if (busy_cnt > 0)
            busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = busy_force || (busy_cnt != 0);

    always @(negedge fp_clk) begin
        if (tx_start) begin
            got_q.push_back(tx_data);
            if (prev_start)
                consec_err++;
        end
        prev_start = tx_start;
        if (pkt_done)
            done_cnt++;
    end

    function automatic void push_model(input logic [7:0] cmd, input logic [2:0] plen,
                                       input logic [39:0] prm);
        int         n;
        logic [15:0] chk;
        logic [7:0] b[$];
        n = (plen > 3'd5) ? 5 : int'(plen);
        b = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'(n + 3), cmd};
        for (int k = 0; k < n; k++)
            b.push_back(prm[39 - 8*k -: 8]);
        chk = 16'd0;
        for (int k = 6; k < b.size(); k++)
            chk = chk + {8'd0, b[k]};
        b.push_back(chk[15:8]);
        b.push_back(chk[7:0]);
        foreach (b[k])
            exp_q.push_back(b[k]);
    endfunction

    task automatic issue_cmd(input logic [7:0] cmd, input logic [2:0] plen,
                             input logic [39:0] prm);
        int t;
        t = 0;
        @(negedge fp_clk);
        while (!cmd_ready && t < 2000) begin
            @(negedge fp_clk);
            t++;
        end
        cmd_valid = 1'b1;
        cmd_code  = cmd;
        param_len = plen;
        params    = prm;
        @(negedge fp_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_pkt(input int base, output bit ok);
        int t;
        t = 0;
        while (done_cnt <= base && t < 5000) begin
            @(negedge fp_clk);
            t++;
        end
        ok = (done_cnt > base);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge fp_clk);
        reset = 1'b0;
        @(negedge fp_clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        n_cmp++;
        if (tx_start !== 1'b0) begin n_bad++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        n_cmp++;
        if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_cmp++;
        if (pkt_done !== 1'b0) begin n_bad++; $display("FAIL reset_pkt_done: got %b expected 0", pkt_done); end
`ifdef R305_PKT_COUNT_EN
        n_cmp++;
        if (pkt_count !== 8'h00) begin n_bad++; $display("FAIL reset_pkt_count: got %h expected 00", pkt_count); end
`endif
    endtask

    task automatic test_genimg;
        int base;
        bit ok;
        busy_len = 10;
        exp_q = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h03, 8'h01, 8'h00, 8'h05};
        got_q.delete();
        base = done_cnt;
        issue_cmd(8'h01, 3'd0, 40'd0);
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL genimg_busy_ready: got %b expected 0", cmd_ready); end
        wait_pkt(base, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL genimg_timeout: pkt_done count %0d expected %0d", done_cnt, base + 1); end
        repeat (30) @(negedge fp_clk);
        n_cmp++;
        if (done_cnt !== base + 1) begin n_bad++; $display("FAIL genimg_done_count: got %0d expected %0d", done_cnt - base, 1); end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL genimg_len: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL genimg_byte%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_search;
        int base;
        bit ok;
        busy_len = 3;
        exp_q = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h08, 8'h04,
                  8'h01, 8'h00, 8'h00, 8'h00, 8'hA3, 8'h00, 8'hB1};
        got_q.delete();
        base = done_cnt;
        issue_cmd(8'h04, 3'd5, 40'h01_0000_00A3);
        wait_pkt(base, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL search_timeout: pkt_done count %0d expected %0d", done_cnt, base + 1); end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL search_len: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL search_byte%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_clamp_overlap;
        int base;
        int t;
        bit ok;
        busy_len = 4;
        got_q.delete();
        push_model(8'h1D, 3'd7, 40'hDE_AD_BE_EF_5A);
        base = done_cnt;
        issue_cmd(8'h1D, 3'd7, 40'hDE_AD_BE_EF_5A);
        t = 0;
        while (got_q.size() < 3 && t < 500) begin @(negedge fp_clk); t++; end
        cmd_valid = 1'b1;
        cmd_code  = 8'h55;
        param_len = 3'd2;
        params    = 40'h11_2233_4455;
        repeat (4) @(negedge fp_clk);
        cmd_valid = 1'b0;
        wait_pkt(base, ok);
        repeat (150) @(negedge fp_clk);
        n_cmp++;
        if (done_cnt !== base + 1) begin n_bad++; $display("FAIL clamp_done_count: got %0d expected %0d", done_cnt - base, 1); end
        n_cmp++;
        if (got_q.size() !== 17) begin n_bad++; $display("FAIL clamp_len: got %0d bytes expected 17", got_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL clamp_byte%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_busy_stall;
        int base;
        bit ok;
        busy_len = 2;
        got_q.delete();
        push_model(8'h0B, 3'd1, 40'h42_0000_0000);
        base = done_cnt;
        busy_force = 1'b1;
        issue_cmd(8'h0B, 3'd1, 40'h42_0000_0000);
        repeat (49) @(negedge fp_clk);
        n_cmp++;
        if (got_q.size() !== 0) begin n_bad++; $display("FAIL stall_no_start: got %0d starts expected 0", got_q.size()); end
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready: got %b expected 0", cmd_ready); end
        busy_force = 1'b0;
        wait_pkt(base, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL stall_timeout: pkt_done count %0d expected %0d", done_cnt, base + 1); end
        n_cmp++;
        if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL stall_len: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL stall_byte%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid;
        int base;
        int t;
        bit ok;
        busy_len = 10;
        got_q.delete();
        base = done_cnt;
        issue_cmd(8'h01, 3'd0, 40'd0);
        t = 0;
        while (got_q.size() < 6 && t < 1000) begin @(negedge fp_clk); t++; end
        // A command presented alongside reset must be dropped.
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_code  = 8'h02;
        @(negedge fp_clk);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        got_q.delete();
        repeat (200) @(negedge fp_clk);
        n_cmp++;
        if (got_q.size() !== 0) begin n_bad++; $display("FAIL abort_no_start: got %0d starts expected 0", got_q.size()); end
        n_cmp++;
        if (done_cnt !== base) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - base); end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b expected 1", cmd_ready); end
        push_model(8'h01, 3'd0, 40'd0);
        got_q.delete();
        base = done_cnt;
        issue_cmd(8'h01, 3'd0, 40'd0);
        wait_pkt(base, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL abort_retry_timeout: pkt_done count %0d expected %0d", done_cnt, base + 1); end
        n_cmp++;
        if (got_q.size() !== 12) begin n_bad++; $display("FAIL abort_retry_len: got %0d bytes expected 12", got_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                n_bad++;
                $display("FAIL abort_retry_byte%0d: got %h expected %h", k, (k < got_q.size()) ? got_q[k] : 8'hxx, exp_q[k]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

`ifdef R305_PKT_COUNT_EN
    task automatic test_pkt_count;
        int base;
        bit ok;
        busy_len = 1;
        reset = 1'b1;
        @(negedge fp_clk);
        reset = 1'b0;
        for (int p = 0; p < 257; p++) begin
            base = done_cnt;
            issue_cmd(8'h01, 3'd0, 40'd0);
            wait_pkt(base, ok);
            got_q.delete();
            if (!ok) begin
                n_cmp++;
                n_bad++;
                $display("FAIL count_timeout: packet %0d did not complete", p);
                break;
            end
        end
        @(negedge fp_clk);
        n_cmp++;
        if (pkt_count !== 8'h01) begin n_bad++; $display("FAIL pkt_count_wrap: got %h expected 01", pkt_count); end
    endtask
`endif

    task automatic test_no_consecutive;
        n_cmp++;
        if (consec_err !== 0) begin n_bad++; $display("FAIL consecutive_start: got %0d events expected 0", consec_err); end
    endtask

    initial begin
        test_reset;
        test_genimg;
        test_search;
        test_clamp_overlap;
        test_busy_stall;
        test_reset_mid;
`ifdef R305_PKT_COUNT_EN
        test_pkt_count;
`endif
        test_no_consecutive;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
